uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Frame-level controller that sits directly behind the UART receive driver.
- Consumes its one-cycle byte strobes and sequences them into fixed 5-byte command frames: header, address, data high, data low, checksum.
- Validates each frame and presents it as a register-write command with a valid/ready handshake to the configuration register bank.
- Flags checksum, inter-byte timeout and overrun errors.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CNT, 250_000, max clk cycles allowed between consecutive bytes of one frame (10 ms at 25 MHz); legal range 2..2^24-1.

Ports:
- clk  input  1  system clock.
- rstn  input  1  synchronous active-low reset.
- uart_rx_done  input  1  one-cycle byte-valid strobe from the UART receiver.
- uart_rx_data  input  8  received byte, valid when uart_rx_done=1.
- cmd_valid  output  1  command available.
- cmd_ready  input  1  consumer accepts the command.
- cmd_addr  output  8  register address.
- cmd_wdata  output  16  register write data, {data_hi, data_lo}.
- err_pulse  output  1  one-cycle error strobe.
- err_code  output  2  error cause, valid with err_pulse: 1=checksum, 2=timeout, 3=overrun.
- busy  output  1  high in any state other than IDLE.
- frame_cnt  output  16  count of accepted good frames.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous, active-low: sampled only on posedge clk when rstn=0.
  - Reset values: cmd_valid=0, cmd_addr=0, cmd_wdata=0, err_pulse=0, err_code=0, busy=0, frame_cnt=0, state=IDLE, timeout counter=0.
  - Reset asserted mid-frame or while cmd_valid=1 abandons everything; no error pulse is generated.
- State machine: IDLE -> ADDR -> DATH -> DATL -> CSUM -> OUT.
  - IDLE: on uart_rx_done with data==HEADER, go to ADDR. A non-header byte is silently discarded and the FSM stays in IDLE.
  - ADDR, DATH, DATL: each uart_rx_done latches the byte into the addr, hi or lo shadow register respectively and advances to the next state.
  - CSUM: on uart_rx_done, compare the byte with (addr+hi+lo) mod 256. The header is not included in the sum.
    - Match: go to OUT, load cmd_addr/cmd_wdata, set cmd_valid=1 on the next edge. Latency is one cycle after the checksum strobe.
    - Mismatch: err_pulse=1, err_code=1, go to IDLE; cmd outputs unchanged.
  - OUT: cmd_valid held high and cmd_addr/cmd_wdata held stable until cmd_ready=1.
    - Transfer occurs on the cycle with cmd_valid&cmd_ready. On that edge, cmd_valid goes to 0, frame_cnt increments (wraps 16'hFFFF->0), and the FSM goes to IDLE.
    - A uart_rx_done while in OUT drops the byte and gives err_pulse=1, err_code=3. The FSM stays in OUT; the command is not lost.
    - cmd_ready while cmd_valid=0 is ignored.
- Timeout:
  - A 24-bit counter runs only in ADDR, DATH, DATL and CSUM. It clears on every uart_rx_done and on entry to those states.
  - When the counter reaches TIMEOUT_CNT-1 with no strobe that cycle: err_pulse=1, err_code=2, go to IDLE.
  - A strobe arriving on the same cycle as the terminal count wins: the byte is processed and there is no timeout.
  - The counter is held at 0 in IDLE and OUT; there is no timeout while waiting for cmd_ready.
- err_pulse is exactly one cycle wide. err_code holds its last value until the next error.
- busy = (state != IDLE), registered.
- A header byte received in ADDR, DATH, DATL or CSUM is treated as ordinary data; there is no resynchronisation.

Test Plan:
- Good frame: bytes A5,12,34,56,9C with cmd_ready=1 -> cmd_valid for 1 cycle, starting 1 cycle after the 9C strobe; cmd_addr=0x12, cmd_wdata=0x3456; frame_cnt 0->1; no err_pulse.
- Backpressure and overrun: good frame with cmd_ready=0 for 20 cycles, extra byte 0x77 injected meanwhile -> cmd_valid stays high with stable outputs; one err_pulse with err_code=3; transfer happens when cmd_ready rises; frame_cnt=1.
- Bad checksum: A5,12,34,56,9D -> err_pulse with err_code=1 one cycle after the last strobe; cmd_valid never rises; busy=0; a following good frame is accepted.
- Timeout: with TIMEOUT_CNT=100, send A5,12 then idle -> err_pulse with err_code=2 exactly 99 cycles after the 0x12 strobe. A strobe placed exactly on that cycle instead -> no error, the FSM advances to DATL.
- Garbage and reset: bytes 00,FF before A5 are ignored. Assert rstn=0 for 1 cycle after the DATH byte -> all outputs at reset values, no err_pulse. The next full frame parses correctly.
- Counter wrap: preload 65535 good frames (or force frame_cnt) -> the next accepted frame gives frame_cnt=0.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte UART frames into validated register-write commands.
module uart_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CNT = 250_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_rx_done,
    input  logic [7:0]  uart_rx_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_wdata,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] DATH = 3'd2;
    localparam logic [2:0] DATL = 3'd3;
    localparam logic [2:0] CSUM = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;
    // The error fires on the edge where the counter would reach TIMEOUT_CNT-1.
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CNT - 2);

    logic [2:0]  state, state_n;
    logic [23:0] tmo_cnt;
    logic [7:0]  addr_r, hi_r, lo_r, sum;
    logic        in_frame, in_frame_n, tmo, csum_ok, err_n;
    logic [1:0]  code_n;

    always_comb begin
        in_frame = state inside {ADDR, DATH, DATL, CSUM};
        sum      = addr_r + hi_r + lo_r;
        csum_ok  = uart_rx_data == sum;
        tmo      = in_frame && !uart_rx_done && tmo_cnt == TMO_LAST;
        state_n  = state;
        case (state)
            IDLE:    state_n = (uart_rx_done && uart_rx_data == HEADER) ? ADDR : IDLE;
            ADDR:    state_n = uart_rx_done ? DATH : tmo ? IDLE : ADDR;
            DATH:    state_n = uart_rx_done ? DATL : tmo ? IDLE : DATH;
            DATL:    state_n = uart_rx_done ? CSUM : tmo ? IDLE : DATL;
            CSUM:    state_n = uart_rx_done ? (csum_ok ? OUT : IDLE) : tmo ? IDLE : CSUM;
            OUT:     state_n = cmd_ready ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
        in_frame_n = state_n inside {ADDR, DATH, DATL, CSUM};
        err_n      = tmo || (uart_rx_done && (state == OUT || (state == CSUM && !csum_ok)));
        code_n     = state == OUT ? 2'd3 : tmo ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            addr_r    <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            busy      <= state_n != IDLE;
            tmo_cnt   <= (in_frame_n && state_n == state && !uart_rx_done) ? tmo_cnt + 24'd1 : '0;
            err_pulse <= err_n;
            if (err_n) err_code <= code_n;
            if (uart_rx_done && state == ADDR) addr_r <= uart_rx_data;
            if (uart_rx_done && state == DATH) hi_r <= uart_rx_data;
            if (uart_rx_done && state == DATL) lo_r <= uart_rx_data;
            if (uart_rx_done && state == CSUM && csum_ok) begin
                cmd_valid <= 1'b1;
                cmd_addr  <= addr_r;
                cmd_wdata <= {hi_r, lo_r};
            end
            if (state == OUT && cmd_ready) begin
                cmd_valid <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and random frames checked every cycle against a byte-queue model.
module tb_uart_cmd_parser;
    localparam int TMO = 100;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid, err_pulse, busy;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata, frame_cnt;
    logic [1:0]  err_code;
    int          n_tests = 0, n_fail = 0;

    logic [7:0]  m_q[$];
    bit          m_valid, m_err, m_busy;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata, m_fcnt;
    logic [1:0]  m_code;
    int          m_gap;

    uart_cmd_parser #(.HEADER(8'hA5), .TIMEOUT_CNT(TMO)) dut (
        .clk(clk), .rstn(rstn), .uart_rx_done(rx_done), .uart_rx_data(rx_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .err_pulse(err_pulse), .err_code(err_code),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: collected bytes live in a queue; the checksum covers bytes 1..3.
    task automatic model(input bit d, input logic [7:0] b, input bit r, input bit n);
        if (!n) begin
            m_q = {};
            {m_valid, m_err, m_busy, m_addr, m_wdata, m_fcnt, m_code, m_gap} = '0;
            return;
        end
        m_err = 0;
        if (m_valid) begin
            if (r) begin
                m_valid = 0;
                m_fcnt++;
            end
            if (d) begin
                m_err = 1;
                m_code = 3;
            end
        end else if (m_q.size() == 0) begin
            if (d && b == 8'hA5) begin
                m_q.push_back(b);
                m_gap = 0;
            end
        end else if (d) begin
            m_q.push_back(b);
            m_gap = 0;
            if (m_q.size() == 5) begin
                if (b == 8'(m_q[1] + m_q[2] + m_q[3])) begin
                    m_valid = 1;
                    m_addr = m_q[1];
                    m_wdata = {m_q[2], m_q[3]};
                end else begin
                    m_err = 1;
                    m_code = 1;
                end
                m_q = {};
            end
        end else begin
            m_gap++;
            if (m_gap == TMO - 1) begin
                m_err = 1;
                m_code = 2;
                m_q = {};
            end
        end
        m_busy = m_valid || m_q.size() > 0;
    endtask

    task automatic cyc(input bit d, input logic [7:0] b, input bit r, input bit n);
        rx_done = d;
        rx_data = b;
        cmd_ready = r;
        rstn = n;
        @(posedge clk);
        model(d, b, r, n);
        @(negedge clk);
        check("valid", cmd_valid, m_valid);
        check("addr", cmd_addr, m_addr);
        check("wdata", cmd_wdata, m_wdata);
        check("err_pulse", err_pulse, m_err);
        check("err_code", err_code, m_code);
        check("busy", busy, m_busy);
        check("frame_cnt", frame_cnt, m_fcnt);
    endtask

    task automatic idle(input int k, input bit r);
        repeat (k) cyc(0, 8'h00, r, 1);
    endtask

    task automatic frame(input logic [7:0] a, h, l, c, input bit r);
        cyc(1, 8'hA5, r, 1);
        cyc(1, a, r, 1);
        cyc(1, h, r, 1);
        cyc(1, l, r, 1);
        cyc(1, c, r, 1);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        // Good frame with the consumer ready
        frame(8'h12, 8'h34, 8'h56, 8'h9C, 1);
        check("good_valid", cmd_valid, 1);
        check("good_addr", cmd_addr, 8'h12);
        check("good_wdata", cmd_wdata, 16'h3456);
        cyc(0, 8'h00, 1, 1);
        check("good_cnt", frame_cnt, 1);
        check("good_drop", cmd_valid, 0);
        // Backpressure with an overrun byte
        frame(8'h12, 8'h34, 8'h56, 8'h9C, 0);
        idle(5, 0);
        cyc(1, 8'h77, 0, 1);
        check("ovr_err", err_pulse, 1);
        check("ovr_code", err_code, 3);
        idle(14, 0);
        check("bp_hold", cmd_wdata, 16'h3456);
        cyc(0, 8'h00, 1, 1);
        check("bp_cnt", frame_cnt, 2);
        // Bad checksum, then recovery
        frame(8'h12, 8'h34, 8'h56, 8'h9D, 1);
        check("csum_code", err_code, 1);
        check("csum_busy", busy, 0);
        idle(2, 1);
        frame(8'h01, 8'h02, 8'h03, 8'h06, 1);
        idle(1, 1);
        check("recov_cnt", frame_cnt, 3);
        // Timeout latency measured from the address strobe
        cyc(1, 8'hA5, 1, 1);
        cyc(1, 8'h12, 1, 1);
        lat = -1;
        for (int k = 1; k <= 120; k++) begin
            cyc(0, 8'h00, 1, 1);
            if (err_pulse && lat < 0) lat = k;
        end
        check("tmo_lat", lat, TMO - 1);
        check("tmo_code", err_code, 2);
        // Strobe on the terminal cycle wins
        cyc(1, 8'hA5, 1, 1);
        cyc(1, 8'h12, 1, 1);
        idle(TMO - 2, 1);
        cyc(1, 8'h34, 1, 1);
        check("tmo_race_err", err_pulse, 0);
        cyc(1, 8'h56, 1, 1);
        cyc(1, 8'h9C, 1, 1);
        check("tmo_race_valid", cmd_valid, 1);
        idle(1, 1);
        // Garbage then mid-frame reset
        cyc(1, 8'h00, 1, 1);
        cyc(1, 8'hFF, 1, 1);
        check("garbage_busy", busy, 0);
        cyc(1, 8'hA5, 1, 1);
        cyc(1, 8'h12, 1, 1);
        cyc(1, 8'h34, 1, 1);
        cyc(0, 8'h00, 1, 0);
        check("mrst_cnt", frame_cnt, 0);
        check("mrst_busy", busy, 0);
        frame(8'h20, 8'hAB, 8'hCD, 8'h98, 1);
        check("post_rst_wdata", cmd_wdata, 16'hABCD);
        idle(1, 1);
        // Frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        m_fcnt = 16'hFFFF;
        frame(8'h05, 8'h06, 8'h07, 8'h12, 1);
        idle(1, 1);
        check("wrap_cnt", frame_cnt, 0);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 250) idle(TMO + 10, $urandom_range(1));
            b = 8'($urandom);
            if (m_q.size() == 0 && $urandom_range(9) < 7) b = 8'hA5;
            if (m_q.size() == 4 && $urandom_range(9) < 7) b = 8'(m_q[1] + m_q[2] + m_q[3]);
            cyc($urandom_range(3) == 0, b, $urandom_range(2) == 0, $urandom_range(499) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
